// File: rtl/nvpe_arb_pkg.sv
// Shared types and widths for the NVPE data-port arbiter: master IDs, OBI field widths.
// No logic here; latency and backpressure are defined by the modules that import it.
package nvpe_arb_pkg;

  typedef enum logic {
    MID_CPU  = 1'b0,
    MID_NVPE = 1'b1
  } master_id_e;

  localparam int BE_WIDTH                = 4;
  localparam int DATA_WIDTH              = 32;
  localparam int DEFAULT_MAX_OUTSTANDING = 2;

  function automatic master_id_e other_master(input master_id_e m);
    return (m == MID_CPU) ? MID_NVPE : MID_CPU;
  endfunction

endpackage

// File: rtl/nvpe_arb_id_fifo.sv
// In-order queue of master IDs for outstanding transactions; head visible combinationally, 1-cycle write.
// Push is ignored when full unless a pop happens in the same cycle; pop is ignored when empty.
module nvpe_arb_id_fifo
  import nvpe_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MAX_OUTSTANDING,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  master_id_e       push_id,
  input  logic             pop,
  output master_id_e       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  master_id_e       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A pop frees the slot the push is about to take, so full does not block it.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= MID_CPU;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop_ok) rd_ptr <= ptr_next(rd_ptr);
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/nvpe_data_arbiter.sv
// Two-master to one-slave OBI data arbiter; zero-latency req/gnt and rvalid paths, in-order ID queue.
// Backpressure: s_req_o drops when MAX_OUTSTANDING are unanswered; NVPE_ARB_RR_EN selects round-robin.
module nvpe_data_arbiter
  import nvpe_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  lock_m2_i,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [BE_WIDTH-1:0]   m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  input  logic                  m2_req_i,
  output logic                  m2_gnt_o,
  output logic                  m2_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] m2_addr_i,
  input  logic                  m2_we_i,
  input  logic [BE_WIDTH-1:0]   m2_be_i,
  input  logic [DATA_WIDTH-1:0] m2_wdata_i,
  output logic [DATA_WIDTH-1:0] m2_rdata_o,
  output logic                  s_req_o,
  input  logic                  s_gnt_i,
  input  logic                  s_rvalid_i,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic                  s_we_o,
  output logic [BE_WIDTH-1:0]   s_be_o,
  output logic [DATA_WIDTH-1:0] s_wdata_o,
  input  logic [DATA_WIDTH-1:0] s_rdata_i,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             m1_elig;
  logic             m2_elig;
  logic             win_vld;
  master_id_e       win_id;
  logic             issue_ok;
  logic             pop_ok;
  logic             xfer_gnt;
  master_id_e       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign m1_elig = m1_req_i && !lock_m2_i;
  assign m2_elig = m2_req_i;
  assign win_vld = m1_elig || m2_elig;

`ifdef NVPE_ARB_RR_EN
  master_id_e rr_ptr;

  always_comb begin
    win_id = m1_elig ? MID_CPU : MID_NVPE;
    if (m1_elig && m2_elig) win_id = rr_ptr;
  end

  // The favourite only hands over after it has actually been served.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= MID_CPU;
    end else if (xfer_gnt && (win_id == rr_ptr)) begin
      rr_ptr <= other_master(rr_ptr);
    end
  end
`else
  always_comb begin
    win_id = m1_elig ? MID_CPU : MID_NVPE;
  end
`endif

  assign pop_ok   = s_rvalid_i && (fifo_count != '0);
  assign issue_ok = !fifo_full || pop_ok;
  assign s_req_o  = win_vld && issue_ok;
  assign xfer_gnt = s_req_o && s_gnt_i;

  assign m1_gnt_o = xfer_gnt && (win_id == MID_CPU);
  assign m2_gnt_o = xfer_gnt && (win_id == MID_NVPE);

  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (win_vld) begin
      if (win_id == MID_CPU) begin
        s_addr_o  = m1_addr_i;
        s_we_o    = m1_we_i;
        s_be_o    = m1_be_i;
        s_wdata_o = m1_wdata_i;
      end else begin
        s_addr_o  = m2_addr_i;
        s_we_o    = m2_we_i;
        s_be_o    = m2_be_i;
        s_wdata_o = m2_wdata_i;
      end
    end
  end

  assign m1_rvalid_o = pop_ok && (fifo_head == MID_CPU);
  assign m2_rvalid_o = pop_ok && (fifo_head == MID_NVPE);
  assign m1_rdata_o  = s_rdata_i;
  assign m2_rdata_o  = s_rdata_i;

  nvpe_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (xfer_gnt),
    .push_id (win_id),
    .pop     (pop_ok),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A response with nothing outstanding is a slave protocol violation; latched until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (s_rvalid_i && fifo_empty) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nvpe_data_arbiter.sv
// Self-checking bench for nvpe_data_arbiter: directed scenarios with literal expectations, then random traffic.
// A queue-based reference model predicts every output on every cycle.
module tb_nvpe_data_arbiter;

  localparam int MAXO = 2;
  localparam int AW   = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lock_m2;
  logic          m1_req, m2_req, m1_gnt, m2_gnt, m1_rvalid, m2_rvalid;
  logic [AW-1:0] m1_addr, m2_addr, s_addr;
  logic          m1_we, m2_we, s_we;
  logic [3:0]    m1_be, m2_be, s_be;
  logic [31:0]   m1_wdata, m2_wdata, s_wdata, m1_rdata, m2_rdata, s_rdata;
  logic          s_req, s_gnt, s_rvalid, err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit q[$];
  bit rr_fav;
  bit model_err;
  bit x_pop, x_gnt, x_win, x_err_set;

  always #5 clk = ~clk;

  nvpe_data_arbiter #(.MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .lock_m2_i(lock_m2),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata),
    .m2_req_i(m2_req), .m2_gnt_o(m2_gnt), .m2_rvalid_o(m2_rvalid),
    .m2_addr_i(m2_addr), .m2_we_i(m2_we), .m2_be_i(m2_be),
    .m2_wdata_i(m2_wdata), .m2_rdata_o(m2_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
    .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be),
    .s_wdata_o(s_wdata), .s_rdata_i(s_rdata), .err_o(err)
  );

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic idle();
    lock_m2 = 0; m1_req = 0; m2_req = 0; s_gnt = 0; s_rvalid = 0;
    m1_addr = '0; m2_addr = '0; m1_we = 0; m2_we = 0; m1_be = '0; m2_be = '0;
    m1_wdata = '0; m2_wdata = '0; s_rdata = '0;
  endtask

  // Predict this cycle's outputs from the inputs and model state, then compare.
  task automatic settle();
    bit e1, e2, has, allowed, sreq;
    int cnt;
    #1;
    if (!rst_n) begin
      q.delete();
      rr_fav    = 0;
      model_err = 0;
    end
    e1  = m1_req && !lock_m2;
    e2  = m2_req;
    cnt = q.size();
    x_pop     = s_rvalid && (cnt > 0);
    x_err_set = s_rvalid && (cnt == 0);
    allowed   = (cnt < MAXO) || x_pop;
    has       = e1 || e2;
`ifdef NVPE_ARB_RR_EN
    if (e1 && e2) x_win = rr_fav;
    else          x_win = !e1;
`else
    x_win = !e1;
`endif
    sreq  = has && allowed;
    x_gnt = sreq && s_gnt;

    cmp("s_req",     s_req, sreq);
    cmp("m1_gnt",    m1_gnt, x_gnt && !x_win);
    cmp("m2_gnt",    m2_gnt, x_gnt && x_win);
    cmp("s_addr",    s_addr,  !has ? 32'h0 : (x_win ? m2_addr : m1_addr));
    cmp("s_we",      s_we,    !has ? 1'b0  : (x_win ? m2_we : m1_we));
    cmp("s_be",      s_be,    !has ? 4'h0  : (x_win ? m2_be : m1_be));
    cmp("s_wdata",   s_wdata, !has ? 32'h0 : (x_win ? m2_wdata : m1_wdata));
    cmp("m1_rvalid", m1_rvalid, x_pop && (q[0] == 1'b0));
    cmp("m2_rvalid", m2_rvalid, x_pop && (q[0] == 1'b1));
    cmp("m1_rdata",  m1_rdata, s_rdata);
    cmp("m2_rdata",  m2_rdata, s_rdata);
    cmp("err",       err, model_err);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (x_pop) void'(q.pop_front());
      if (x_gnt) begin
        q.push_back(x_win);
        if (x_win == rr_fav) rr_fav = !rr_fav;
      end
      if (x_err_set) model_err = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); rst_n = 0;
    settle(); tick();
    rst_n = 1;
  endtask

  initial begin
    bit exp_m2;
    idle();
    rst_n = 0;
    @(negedge clk);

    // Reset state
    settle();
    cmp("rst_s_req", s_req, 0);
    cmp("rst_m1_gnt", m1_gnt, 0);
    cmp("rst_m2_rvalid", m2_rvalid, 0);
    cmp("rst_err", err, 0);
    cmp("rst_s_addr", s_addr, 0);
    tick();
    rst_n = 1;

    // Single m1 read
    idle(); m1_req = 1; m1_addr = 32'h100; s_gnt = 1;
    settle();
    cmp("single_gnt", m1_gnt, 1);
    cmp("single_addr", s_addr, 32'h100);
    tick();
    idle(); s_rvalid = 1; s_rdata = 32'hDEADBEEF;
    settle();
    cmp("single_rvalid", m1_rvalid, 1);
    cmp("single_rdata", m1_rdata, 32'hDEADBEEF);
    cmp("single_m2_rvalid", m2_rvalid, 0);
    tick();

    // Conflict from a fresh pointer
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); m1_req = 1; m2_req = 1; s_gnt = 1; s_rvalid = (i > 0);
      m1_addr = 32'h1000 + i; m2_addr = 32'h2000 + i;
`ifdef NVPE_ARB_RR_EN
      exp_m2 = (i % 2) == 1;
`else
      exp_m2 = 0;
`endif
      settle();
      cmp("conflict_m1_gnt", m1_gnt, !exp_m2);
      cmp("conflict_m2_gnt", m2_gnt, exp_m2);
      tick();
    end
    idle(); m2_req = 1; s_gnt = 1; s_rvalid = 1;
    settle();
    cmp("m2_after_m1_drop", m2_gnt, 1);
    tick();
    idle(); s_rvalid = 1;
    settle(); tick();

    // Full queue
    for (int i = 0; i < 2; i++) begin
      idle(); m1_req = 1; s_gnt = 1; m1_addr = 32'h300 + i;
      settle(); tick();
    end
    idle(); m1_req = 1; s_gnt = 1;
    settle();
    cmp("full_s_req", s_req, 0);
    cmp("full_gnt", m1_gnt, 0);
    tick();
    idle(); m1_req = 1; s_gnt = 1; s_rvalid = 1;
    settle();
    cmp("full_pop_gnt", m1_gnt, 1);
    cmp("full_pop_rvalid", m1_rvalid, 1);
    tick();
    idle(); m1_req = 1; s_gnt = 1;
    settle();
    cmp("full_still_full", s_req, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle(); s_rvalid = 1;
      settle(); tick();
    end

    // Interleaved: m2 then m1
    idle(); m2_req = 1; s_gnt = 1; settle(); tick();
    idle(); m1_req = 1; s_gnt = 1; settle(); tick();
    idle(); s_rvalid = 1; s_rdata = 32'hA5A5_0002;
    settle();
    cmp("inter_first_m2", m2_rvalid, 1);
    cmp("inter_first_m1", m1_rvalid, 0);
    tick();
    idle(); s_rvalid = 1; s_rdata = 32'hA5A5_0001;
    settle();
    cmp("inter_second_m1", m1_rvalid, 1);
    cmp("inter_second_m2", m2_rvalid, 0);
    tick();

    // Lock with an m1 transfer already in flight
    idle(); m1_req = 1; s_gnt = 1; settle(); tick();
    idle(); lock_m2 = 1; m1_req = 1; m2_req = 1; s_gnt = 1;
    settle();
    cmp("lock_m2_gnt", m2_gnt, 1);
    cmp("lock_m1_gnt", m1_gnt, 0);
    tick();
    idle(); lock_m2 = 1; s_rvalid = 1;
    settle();
    cmp("lock_m1_rvalid", m1_rvalid, 1);
    tick();
    idle(); lock_m2 = 1; s_rvalid = 1;
    settle();
    cmp("lock_m2_rvalid", m2_rvalid, 1);
    tick();

    // Protocol error
    idle(); s_rvalid = 1;
    settle();
    cmp("errresp_m1_rvalid", m1_rvalid, 0);
    cmp("errresp_m2_rvalid", m2_rvalid, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); settle();
      cmp("err_sticky", err, 1);
      tick();
    end
    idle(); rst_n = 0;
    settle();
    cmp("err_cleared", err, 0);
    tick();
    rst_n = 1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      lock_m2  = ($urandom_range(0, 3) == 0);
      m1_req   = $urandom_range(0, 1);
      m2_req   = $urandom_range(0, 1);
      m1_addr  = $urandom; m2_addr = $urandom;
      m1_we    = $urandom_range(0, 1); m2_we = $urandom_range(0, 1);
      m1_be    = 4'($urandom_range(0, 15)); m2_be = 4'($urandom_range(0, 15));
      m1_wdata = $urandom; m2_wdata = $urandom;
      s_gnt    = ($urandom_range(0, 3) != 0);
      s_rdata  = $urandom;
      if (q.size() > 0) s_rvalid = $urandom_range(0, 1);
      else              s_rvalid = ($urandom_range(0, 49) == 0);
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
